// File: rtl/icache_fetch.sv
// Instruction-fetch stage: direct-mapped, one-word-per-line cache in front of a
// variable-latency instruction memory. Hits return in the same cycle; misses stall.
module icache_fetch #(
  parameter int unsigned ENTRIES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stall,
  input  logic        invalidate,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [15:0] miss_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  typedef enum logic {RUN, WAIT} state_t;

  state_t             state;
  logic [ENTRIES-1:0] lineValid;
  logic [TAG_W-1:0]   tagMem  [ENTRIES];
  logic [31:0]        dataMem [ENTRIES];
  logic               discard;

  logic [IDX_W-1:0] pcIdx;
  logic [TAG_W-1:0] pcTag;
  logic [IDX_W-1:0] fillIdx;
  logic [TAG_W-1:0] fillTag;
  logic             hit;
  logic             fillDone;
  logic             fillWr;
  logic             unusedPcBits;

  assign pcIdx        = pc[IDX_W+1:2];
  assign pcTag        = pc[31:IDX_W+2];
  assign fillIdx      = mem_addr[IDX_W+1:2];
  assign fillTag      = mem_addr[31:IDX_W+2];
  assign unusedPcBits = ^pc[1:0];

  assign hit      = (state == RUN) && lineValid[pcIdx] && (tagMem[pcIdx] == pcTag);
  assign fillDone = (state == WAIT) && mem_req && mem_ack;
  // A fill is dropped if an invalidate arrived with it or while it was outstanding.
  assign fillWr   = fillDone && !invalidate && !discard;

  // Datapath-facing outputs are held at their reset values while reset is asserted.
  always_comb begin
    instr       = 32'h0;
    instr_valid = 1'b0;
    stall       = 1'b0;
    if (reset) begin
      if (hit) begin
        instr       = dataMem[pcIdx];
        instr_valid = 1'b1;
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      lineValid  <= '0;
      discard    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0;
      miss_count <= 16'h0;
    end else begin
      case (state)
        RUN: begin
          if (!hit) begin
            mem_req  <= 1'b1;
            mem_addr <= {pc[31:2], 2'b00};
            discard  <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (fillDone) begin
            mem_req <= 1'b0;
            discard <= 1'b0;
            state   <= RUN;
            if (fillWr) begin
              lineValid[fillIdx] <= 1'b1;
              if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
          end else if (invalidate) begin
            discard <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
      if (invalidate) lineValid <= '0;
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fillWr) begin
      tagMem[fillIdx]  <= fillTag;
      dataMem[fillIdx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: scoreboard of expected instruction words
// plus cycle-level checks of stall, fill request and miss counter behaviour.
module tb_icache_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        invalidate;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] miss_count;

  int          nChecks = 0;
  int          nErrors = 0;
  logic [15:0] expCnt  = 16'h0;
  logic [31:0] expQ[$];

  icache_fetch #(.ENTRIES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .stall      (stall),
    .invalidate (invalidate),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h20080005;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pop the scoreboard when the datapath sees a valid word.
  task automatic expectOut(input string tag);
    logic [31:0] e;
    checkEq({tag, ".valid"}, 32'(instr_valid), 32'd1);
    checkEq({tag, ".stall"}, 32'(stall), 32'd0);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkEq({tag, ".instr"}, instr, e);
    end
  endtask

  // Present addr from the next cycle; the memory acks in request cycle k.
  task automatic fetch(input logic [31:0] addr, input bit expHit, input int k);
    int stalls = 0;
    int reqCyc = 0;
    bit done   = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (cyc == 0) begin
        pc = addr;
        expQ.push_back(memWord(addr));
      end
      #2;
      if (instr_valid) begin
        expectOut("fetch");
        checkEq("fetch.stalls", 32'(stalls), expHit ? 32'd0 : 32'(k + 1));
        checkEq("fetch.reqIdle", 32'(mem_req), 32'd0);
        done = 1'b1;
      end else begin
        stalls++;
        checkEq("fetch.stallOnMiss", 32'(stall), 32'd1);
        if (mem_req) begin
          reqCyc++;
          checkEq("fetch.memAddr", mem_addr, addr);
          if (reqCyc == k) begin
            mem_ack   = 1'b1;
            mem_rdata = memWord(addr);
          end
        end
      end
    end
    checkEq("fetch.done", 32'(done), 32'd1);
    if (!done && expQ.size() > 0) void'(expQ.pop_front());
    if (!expHit && expCnt != 16'hFFFF) expCnt++;
    checkEq("fetch.missCount", 32'(miss_count), 32'(expCnt));
  endtask

  // Miss on addr, then an invalidate either one cycle before or together with the ack.
  task automatic invalFill(input logic [31:0] addr, input bit sameCycle);
    @(negedge clk);
    pc = addr;
    expQ.push_back(memWord(addr));
    #2 checkEq("inv.stall0", 32'(stall), 32'd1);
    @(negedge clk);
    #2 checkEq("inv.req1", 32'(mem_req), 32'd1);
    invalidate = 1'b1;
    if (!sameCycle) begin
      @(negedge clk);
      invalidate = 1'b0;
      #2 checkEq("inv.reqHeld", 32'(mem_req), 32'd1);
      checkEq("inv.addrHeld", mem_addr, addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = memWord(addr);
    @(negedge clk);
    invalidate = 1'b0;
    mem_ack    = 1'b0;
    #2 checkEq("inv.reqDropped", 32'(mem_req), 32'd0);
    checkEq("inv.missAgain", 32'(instr_valid), 32'd0);
    checkEq("inv.stallAgain", 32'(stall), 32'd1);
    checkEq("inv.countKept", 32'(miss_count), 32'(expCnt));
    @(negedge clk);
    #2 checkEq("inv.reReq", 32'(mem_req), 32'd1);
    checkEq("inv.reAddr", mem_addr, addr);
    mem_ack   = 1'b1;
    mem_rdata = memWord(addr);
    @(negedge clk);
    mem_ack = 1'b0;
    #2 expectOut("inv");
    expCnt++;
    checkEq("inv.countFill", 32'(miss_count), 32'(expCnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    pc         = 32'h0;
    invalidate = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;

    // Reset values, held while reset is low even though pc=0 would miss.
    repeat (2) @(negedge clk);
    #2;
    checkEq("rst.instr", instr, 32'h0);
    checkEq("rst.valid", 32'(instr_valid), 32'd0);
    checkEq("rst.stall", 32'(stall), 32'd0);
    checkEq("rst.req", 32'(mem_req), 32'd0);
    checkEq("rst.addr", mem_addr, 32'h0);
    checkEq("rst.count", 32'(miss_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Cold fetch, refetch hits, conflict eviction, long latency.
    fetch(32'h0, 1'b0, 1);
    fetch(32'h4, 1'b0, 1);
    fetch(32'h0, 1'b1, 1);
    fetch(32'h4, 1'b1, 1);
    fetch(32'h0, 1'b1, 1);
    fetch(32'h10, 1'b0, 1);
    fetch(32'h0, 1'b0, 2);
    fetch(32'h8, 1'b0, 5);
    fetch(32'h8, 1'b1, 1);

    // Invalidate while a fill is outstanding, then together with the ack.
    invalFill(32'h18, 1'b0);
    invalFill(32'h1C, 1'b1);
    fetch(32'h18, 1'b0, 1);
    fetch(32'h1C, 1'b1, 1);

    // Asynchronous reset in the middle of a fill.
    @(negedge clk);
    pc = 32'h24;
    #2 checkEq("rw.stall0", 32'(stall), 32'd1);
    @(negedge clk);
    #2 checkEq("rw.req1", 32'(mem_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    checkEq("rw.reqDrop", 32'(mem_req), 32'd0);
    checkEq("rw.stallDrop", 32'(stall), 32'd0);
    checkEq("rw.addrClr", mem_addr, 32'h0);
    checkEq("rw.countClr", 32'(miss_count), 32'd0);
    expCnt = 16'h0;
    expQ.delete();
    @(negedge clk);
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #2 checkEq("rw.missAfter", 32'(stall), 32'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    #2 checkEq("rw.lateAckIgnored", 32'(miss_count), 32'd0);
    checkEq("rw.reReq", 32'(mem_req), 32'd1);
    checkEq("rw.reAddr", mem_addr, 32'h24);
    expQ.push_back(memWord(32'h24));
    mem_ack   = 1'b1;
    mem_rdata = memWord(32'h24);
    @(negedge clk);
    mem_ack = 1'b0;
    #2 expectOut("rw");
    expCnt++;
    checkEq("rw.count", 32'(miss_count), 32'(expCnt));

    // Counter saturation.
    @(negedge clk);
    force dut.miss_count = 16'hFFFE;
    #1 release dut.miss_count;
    #1 checkEq("sat.preload", 32'(miss_count), 32'h0000FFFE);
    expCnt = 16'hFFFE;
    fetch(32'h28, 1'b0, 1);
    fetch(32'h2C, 1'b0, 1);
    fetch(32'h28, 1'b1, 1);
    fetch(32'h24, 1'b1, 1);

    checkEq("sb.empty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
